// File: rtl/bj_pkg.sv
// Shared blackjack definitions: game-state encoding seen by the win/lose pulse
// logic, and the card-value clamp.
package bj_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      UNDER18 = 2'b01,
      CLEAR18 = 2'b10,
      OVER18  = 2'b11
   } bj_state_t;

   // Face code 0 is an ace counted low; codes above 10 are picture cards.
   function automatic logic [4:0] card_points(input logic [3:0] code);
      if (code == 4'd0)
         return 5'd1;
      else if (code > 4'd10)
         return 5'd10;
      else
         return {1'b0, code};
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; synchronous clear.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (clear)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/round_sequencer.sv
// Sequences one blackjack round: deals cards over req/valid, classifies the
// hand against TARGET, holds the result, and keeps win/lose/fold tallies.
module round_sequencer
   import bj_pkg::*;
#(
   parameter int unsigned TARGET      = 18,
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned TIMEOUT     = 1000,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             hit,
   input  logic             stand,
   input  logic             card_valid,
   input  logic [3:0]       card_val,
   output logic             card_req,
   output logic [1:0]       cstate,
   output logic [1:0]       nstate,
   output logic [4:0]       sum,
   output logic [CNT_W-1:0] win_cnt,
   output logic [CNT_W-1:0] lose_cnt,
   output logic [CNT_W-1:0] fold_cnt,
   output logic             busy
);

   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);
   localparam logic [4:0]        TARGET_SUM = 5'(TARGET);

   bj_state_t         state_q, state_d;
   logic [4:0]        sum_q, new_sum;
   logic              req_q;
   logic [HOLD_W-1:0] hold_q;
   logic [TMO_W-1:0]  tmo_q;
   logic              accept, fold, hold_done;
   logic              win_inc, lose_inc, tally_clr;

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      fold      = 1'b0;
      hold_done = 1'b0;
      new_sum   = sum_q + card_points(card_val);
      case (state_q)
         IDLE: begin
            if (start)
               state_d = UNDER18;
         end
         UNDER18: begin
            accept = req_q && card_valid;
            // Idle timeout only runs with no card outstanding and no hit this cycle.
            fold   = stand || (!req_q && !hit && (tmo_q == TMO_LAST));
            if (fold)
               state_d = IDLE;
            else if (accept) begin
               if (new_sum == TARGET_SUM)
                  state_d = CLEAR18;
               else if (new_sum > TARGET_SUM)
                  state_d = OVER18;
            end
         end
         CLEAR18, OVER18: begin
            hold_done = (hold_q == HOLD_LAST);
            if (hold_done)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sum_q  <= '0;
         req_q  <= 1'b0;
         hold_q <= '0;
         tmo_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  sum_q  <= '0;
                  req_q  <= 1'b1;
                  hold_q <= '0;
                  tmo_q  <= '0;
               end
            end
            UNDER18: begin
               // Fold wins over a same-cycle card: the card is dropped unsummed.
               if (fold) begin
                  req_q <= 1'b0;
                  tmo_q <= '0;
               end else if (accept) begin
                  sum_q  <= new_sum;
                  req_q  <= 1'b0;
                  tmo_q  <= '0;
                  hold_q <= '0;
               end else if (!req_q) begin
                  if (hit) begin
                     req_q <= 1'b1;
                     tmo_q <= '0;
                  end else begin
                     tmo_q <= tmo_q + 1'b1;
                  end
               end
            end
            CLEAR18, OVER18: begin
               hold_q <= hold_done ? '0 : hold_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign win_inc   = hold_done && (state_q == CLEAR18);
   assign lose_inc  = hold_done && (state_q == OVER18);
   assign tally_clr = !rst;

   sat_counter #(.W(CNT_W)) u_win (
      .clk   (clk),
      .clear (tally_clr),
      .inc   (win_inc),
      .cnt   (win_cnt)
   );

   sat_counter #(.W(CNT_W)) u_lose (
      .clk   (clk),
      .clear (tally_clr),
      .inc   (lose_inc),
      .cnt   (lose_cnt)
   );

   sat_counter #(.W(CNT_W)) u_fold (
      .clk   (clk),
      .clear (tally_clr),
      .inc   (fold),
      .cnt   (fold_cnt)
   );

   assign cstate   = state_q;
   assign nstate   = state_d;
   assign sum      = sum_q;
   assign card_req = req_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer: directed vector table, hand-written
// corner sequences, then random stimulus against a behavioural round model.
module tb_round_sequencer;

   localparam int TARGET  = 18;
   localparam int HOLD    = 4;
   localparam int TIMEOUT = 1000;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_UNDER = 2'b01;
   localparam logic [1:0] S_CLEAR = 2'b10;
   localparam logic [1:0] S_OVER  = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0, hit = 1'b0, stand = 1'b0, card_valid = 1'b0;
   logic [3:0] card_val = 4'd0;

   logic       req_a, busy_a, req_b, busy_b;
   logic [1:0] cs_a, ns_a, cs_b, ns_b;
   logic [4:0] sum_a, sum_b;
   logic [7:0] win_a, lose_a, fold_a;
   logic [1:0] win_b, lose_b, fold_b;

   always #5 clk = ~clk;

   round_sequencer #(.TARGET(18), .HOLD_CYCLES(4), .TIMEOUT(1000), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .hit(hit), .stand(stand),
      .card_valid(card_valid), .card_val(card_val), .card_req(req_a),
      .cstate(cs_a), .nstate(ns_a), .sum(sum_a), .win_cnt(win_a),
      .lose_cnt(lose_a), .fold_cnt(fold_a), .busy(busy_a)
   );

   round_sequencer #(.TARGET(18), .HOLD_CYCLES(4), .TIMEOUT(1000), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .hit(hit), .stand(stand),
      .card_valid(card_valid), .card_val(card_val), .card_req(req_b),
      .cstate(cs_b), .nstate(ns_b), .sum(sum_b), .win_cnt(win_b),
      .lose_cnt(lose_b), .fold_cnt(fold_b), .busy(busy_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural round model: whole-hand bookkeeping with plain integers.
   logic [1:0] m_st;
   int         m_sum, m_idle, m_held, m_win, m_lose, m_fold;
   bit         m_req;

   function automatic int points(input int code);
      if (code == 0) return 1;
      if (code > 10) return 10;
      return code;
   endfunction

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_st = S_IDLE; m_sum = 0; m_req = 0; m_idle = 0; m_held = 0;
      m_win = 0; m_lose = 0; m_fold = 0;
   endtask

   task automatic model_step(input bit s, input bit h, input bit sd, input bit v,
                             input int val, input bit commit, output logic [1:0] ns);
      int nsum, nidle, nheld, dw, dl, df;
      bit nreq;
      nsum = m_sum; nreq = m_req; nidle = m_idle; nheld = m_held;
      dw = 0; dl = 0; df = 0;
      ns = m_st;
      case (m_st)
         S_IDLE: if (s) begin
            ns = S_UNDER; nsum = 0; nreq = 1; nidle = 0;
         end
         S_UNDER: begin
            if (sd) begin
               ns = S_IDLE; nreq = 0; df = 1;
            end else if (m_req && v) begin
               nsum = m_sum + points(val);
               ns = (nsum == TARGET) ? S_CLEAR : (nsum > TARGET) ? S_OVER : S_UNDER;
               nreq = 0; nidle = 0; nheld = 0;
            end else if (!m_req) begin
               if (h) begin
                  nreq = 1; nidle = 0;
               end else if (m_idle + 1 == TIMEOUT) begin
                  ns = S_IDLE; df = 1;
               end else begin
                  nidle = m_idle + 1;
               end
            end
         end
         default: begin
            if (m_held + 1 == HOLD) begin
               ns = S_IDLE;
               if (m_st == S_CLEAR) dw = 1; else dl = 1;
            end else begin
               nheld = m_held + 1;
            end
         end
      endcase
      if (commit) begin
         m_st = ns; m_sum = nsum; m_req = nreq; m_idle = nidle; m_held = nheld;
         m_win += dw; m_lose += dl; m_fold += df;
      end
   endtask

   task automatic check_outputs();
      chk("cstate", cs_a, m_st);
      chk("cstate_w2", cs_b, m_st);
      chk("sum", sum_a, m_sum);
      chk("card_req", req_a, m_req);
      chk("busy", busy_a, m_st != S_IDLE);
      chk("win_cnt", win_a, sat(m_win, 8));
      chk("lose_cnt", lose_a, sat(m_lose, 8));
      chk("fold_cnt", fold_a, sat(m_fold, 8));
      chk("win_cnt_w2", win_b, sat(m_win, 2));
      chk("lose_cnt_w2", lose_b, sat(m_lose, 2));
      chk("fold_cnt_w2", fold_b, sat(m_fold, 2));
   endtask

   // One clock: drive, check nstate, clock, check registered outputs.
   task automatic step(input bit s, input bit h, input bit sd, input bit v,
                       input logic [3:0] val, output logic [1:0] ns_seen);
      logic [1:0] exp_ns;
      start = s; hit = h; stand = sd; card_valid = v; card_val = val;
      #1;
      model_step(s, h, sd, v, int'(val), 1'b0, exp_ns);
      ns_seen = ns_a;
      chk("nstate", ns_a, exp_ns);
      chk("nstate_w2", ns_b, exp_ns);
      @(posedge clk);
      model_step(s, h, sd, v, int'(val), 1'b1, exp_ns);
      #1;
      check_outputs();
   endtask

   task automatic reset_cycle();
      rst = 1'b0;
      start = 0; hit = 0; stand = 0; card_valid = 0; card_val = 4'd0;
      @(posedge clk);
      model_reset();
      #1;
      rst = 1'b1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      logic [1:0] d;
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'd0, d);
   endtask

   task automatic win_round();
      logic [1:0] d;
      step(1, 0, 0, 0, 4'd0, d);
      step(0, 0, 0, 1, 4'd10, d);
      step(0, 1, 0, 0, 4'd0, d);
      step(0, 0, 0, 1, 4'd8, d);
      idle(HOLD);
   endtask

   typedef struct {
      bit         s, h, sd, v;
      logic [3:0] val;
      logic [1:0] ns, cs;
      int         sum;
      bit         req;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit s, input bit h, input bit sd, input bit v,
                               input logic [3:0] val, input logic [1:0] ns,
                               input logic [1:0] cs, input int sm, input bit rq);
      vec_t e;
      e.s = s; e.h = h; e.sd = sd; e.v = v; e.val = val;
      e.ns = ns; e.cs = cs; e.sum = sm; e.req = rq;
      tbl.push_back(e);
   endfunction

   initial begin
      logic [1:0] nsb;

      // Cards 10,8 -> CLEAR18 held four cycles
      add(1,0,0,0, 0, S_UNDER, S_UNDER, 0, 1);
      add(0,0,0,1,10, S_UNDER, S_UNDER, 10, 0);
      add(0,1,0,0, 0, S_UNDER, S_UNDER, 10, 1);
      add(0,0,0,1, 8, S_CLEAR, S_CLEAR, 18, 0);
      for (int i = 0; i < 3; i++) add(0,0,0,0,0, S_CLEAR, S_CLEAR, 18, 0);
      add(0,0,0,0, 0, S_IDLE, S_IDLE, 18, 0);
      // Cards 10,5,9 -> OVER18
      add(1,0,0,0, 0, S_UNDER, S_UNDER, 0, 1);
      add(0,0,0,1,10, S_UNDER, S_UNDER, 10, 0);
      add(0,1,0,0, 0, S_UNDER, S_UNDER, 10, 1);
      add(0,0,0,1, 5, S_UNDER, S_UNDER, 15, 0);
      add(0,1,0,0, 0, S_UNDER, S_UNDER, 15, 1);
      add(0,0,0,1, 9, S_OVER, S_OVER, 24, 0);
      for (int i = 0; i < 3; i++) add(0,0,0,0,0, S_OVER, S_OVER, 24, 0);
      add(0,0,0,0, 0, S_IDLE, S_IDLE, 24, 0);
      // Codes 0,13,7 count as 1,10,7
      add(1,0,0,0, 0, S_UNDER, S_UNDER, 0, 1);
      add(0,0,0,1, 0, S_UNDER, S_UNDER, 1, 0);
      add(0,1,0,0, 0, S_UNDER, S_UNDER, 1, 1);
      add(0,0,0,1,13, S_UNDER, S_UNDER, 11, 0);
      add(0,1,0,0, 0, S_UNDER, S_UNDER, 11, 1);
      add(0,0,0,1, 7, S_CLEAR, S_CLEAR, 18, 0);
      for (int i = 0; i < 3; i++) add(0,0,0,0,0, S_CLEAR, S_CLEAR, 18, 0);
      add(0,0,0,0, 0, S_IDLE, S_IDLE, 18, 0);

      model_reset();
      reset_cycle();
      chk("reset_cstate", cs_a, S_IDLE);
      chk("reset_sum", sum_a, 0);

      foreach (tbl[i]) begin
         step(tbl[i].s, tbl[i].h, tbl[i].sd, tbl[i].v, tbl[i].val, nsb);
         chk("tbl_nstate", nsb, tbl[i].ns);
         chk("tbl_cstate", cs_a, tbl[i].cs);
         chk("tbl_sum", sum_a, tbl[i].sum);
         chk("tbl_card_req", req_a, tbl[i].req);
      end
      chk("tbl_wins", win_a, 2);
      chk("tbl_losses", lose_a, 1);

      // stand together with a card: card discarded, hand folded
      step(1, 0, 0, 0, 4'd0, nsb);
      step(0, 0, 0, 1, 4'd7, nsb);
      step(0, 1, 0, 0, 4'd0, nsb);
      step(0, 0, 1, 1, 4'd5, nsb);
      chk("stand_nstate", nsb, S_IDLE);
      chk("stand_cstate", cs_a, S_IDLE);
      chk("stand_sum", sum_a, 7);
      chk("stand_card_req", req_a, 0);
      chk("stand_fold_cnt", fold_a, 1);

      // idle timeout: fold on the TIMEOUT-th idle cycle after the accept
      step(1, 0, 0, 0, 4'd0, nsb);
      step(0, 0, 0, 1, 4'd5, nsb);
      idle(TIMEOUT - 1);
      chk("tmo_still_under", cs_a, S_UNDER);
      step(0, 0, 0, 0, 4'd0, nsb);
      chk("tmo_nstate", nsb, S_IDLE);
      chk("tmo_cstate", cs_a, S_IDLE);
      chk("tmo_fold_cnt", fold_a, 2);

      // a hit on the 999th idle cycle restarts the timeout
      step(1, 0, 0, 0, 4'd0, nsb);
      step(0, 0, 0, 1, 4'd5, nsb);
      idle(TIMEOUT - 2);
      step(0, 1, 0, 0, 4'd0, nsb);
      step(0, 0, 0, 1, 4'd2, nsb);
      idle(TIMEOUT - 1);
      chk("tmo_restart_under", cs_a, S_UNDER);
      chk("tmo_restart_sum", sum_a, 7);
      step(0, 0, 0, 0, 4'd0, nsb);
      chk("tmo_restart_fold", fold_a, 3);

      // tally saturation in the 2-bit instance
      win_round();
      win_round();
      chk("sat_win_w2_a", win_b, 3);
      win_round();
      chk("sat_win_w2_b", win_b, 3);
      chk("sat_win_w8", win_a, 5);

      // reset during the OVER18 hold credits nothing
      reset_cycle();
      step(1, 0, 0, 0, 4'd0, nsb);
      step(0, 0, 0, 1, 4'd10, nsb);
      step(0, 1, 0, 0, 4'd0, nsb);
      step(0, 0, 0, 1, 4'd9, nsb);
      idle(2);
      chk("midrst_in_hold", cs_a, S_OVER);
      reset_cycle();
      chk("midrst_cstate", cs_a, S_IDLE);
      chk("midrst_lose", lose_a, 0);
      idle(HOLD);
      chk("midrst_lose_later", lose_a, 0);

      // random stimulus against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 999) < 3) begin
            reset_cycle();
         end else begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)), nsb);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Sequences one blackjack round and drives the 2-bit game state that the win/lose pulse logic consumes. It takes player start/hit/stand requests and fetches cards from the card source over a req/valid handshake. It accumulates the hand total, classifies it against the target, holds the result state for display, then returns to IDLE. It also keeps saturating win/lose/fold tallies.

## Interface
- TARGET, 18: hand total that wins; above it busts.
- HOLD_CYCLES, 4: cycles CLEAR18/OVER18 is held before returning to IDLE (≥1).
- TIMEOUT, 1000: idle cycles allowed in UNDER18 with no hit/stand before auto-fold (≥1).
- CNT_W, 8: width of tally counters.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse, begin round (honoured only in IDLE).
- hit  in  1  one-cycle pulse, request one more card.
- stand  in  1  one-cycle pulse, fold the current hand.
- card_valid  in  1  card source has card_val ready.
- card_val  in  4  card value; 0 counts as 1, 11–15 count as 10.
- card_req  out  1  registered request to card source.
- cstate  out  2  registered state: IDLE=00, UNDER18=01, CLEAR18=10, OVER18=11.
- nstate  out  2  combinational next state.
- sum  out  5  current hand total.
- win_cnt, lose_cnt, fold_cnt  out  CNT_W  saturating tallies.
- busy  out  1  cstate != IDLE.

## Operation
- Reset (rst=0 at posedge): cstate=IDLE, sum=0, card_req=0, hold/timeout counters=0, all tallies=0.
- IDLE + start: sum<=0, cstate<=UNDER18, card_req<=1 (first card auto-dealt).
- Card accept: card_req && card_valid in the same cycle. sum<=sum+val. card_req<=0. Timeout counter clears.
- Classification of the new total: ==TARGET → CLEAR18; >TARGET → OVER18; else stay UNDER18.
- UNDER18, no request outstanding, hit: card_req<=1. hit while card_req=1 is ignored.
- UNDER18, stand: go to IDLE, fold_cnt++.
  - Any outstanding card_req drops.
  - A card_valid in that cycle is discarded and sum is unchanged.
  - stand overrides a simultaneous hit or card accept.
- UNDER18 timeout: counter increments each cycle with no hit/stand/accept. While card_req=1 it does not count. On reaching TIMEOUT-1 the hand folds exactly as stand does.
- CLEAR18/OVER18: hold counter runs 0..HOLD_CYCLES-1. On the last count nstate=IDLE and the state moves to IDLE. win_cnt++ (CLEAR18) or lose_cnt++ (OVER18) in that same cycle.
- start, hit and stand are ignored in CLEAR18/OVER18. start is ignored outside IDLE.
- Tallies saturate at 2^CNT_W-1.
- Width: max total is TARGET-1+10=27, which fits 5 bits; the adder is 5-bit with no overflow possible for TARGET ≤ 21.
- card_val has no effect when card_req=0.

## Timing
- start at cycle N → cstate=UNDER18 and card_req=1 at N+1.
- Accept at cycle N → sum and cstate updated at N+1, card_req=0 at N+1.
- hit at N → card_req=1 at N+1. Minimum hit-to-new-sum is 2 cycles with a zero-wait source.
- Hold: cstate=CLEAR18/OVER18 for exactly HOLD_CYCLES cycles. nstate=IDLE is combinationally visible in the final cycle. Tallies update at the posedge leaving that cycle.
- nstate always equals the value cstate takes at the next posedge, absent reset.
- Reset mid-round: the next posedge with rst=0 forces IDLE. No tally update and no nstate=IDLE transition is credited as a result.

## Structure
- Shared package bj_pkg holds the state localparams IDLE/UNDER18/CLEAR18/OVER18 (2-bit) and the card clamp function. The win/lose pulse logic imports the same encoding.
- One sub-module, sat_counter (parameter W; inc, clear), instanced three times for the tallies.
- Hold and timeout counters stay inline.

## Test plan
- Reset, then start, then cards 10,8 with zero-wait valid → sum=18, CLEAR18 held 4 cycles, nstate=IDLE on the 4th, win_cnt=1.
- start, then cards 10,5,9 → sum=24, OVER18, lose_cnt=1, back to IDLE after 4 cycles.
- start, card 7, then stand and card_valid in the same cycle as the next card_req → IDLE, sum stays 7, fold_cnt=1, card_req=0.
- card_val=0 then 13 then 7 → counted as 1,10,7 → sum=18, CLEAR18.
- start, one card 5, no input for TIMEOUT cycles → fold at exactly TIMEOUT cycles after the accept. A hit at cycle 999 instead restarts the count.
- CNT_W=2, four wins → win_cnt=3 and stays 3. rst asserted during OVER18 hold → IDLE next cycle, lose_cnt unchanged.
